scram_dsc: RTL and testbench

SCRAM_DSC -- requirements
Module: scram_dsc

---
 rtl/scram_pkg.sv | 21 ++
 rtl/scram_core.sv | 44 ++++
 rtl/scram_dsc.sv | 168 ++++++++++++++++
 tb/tb_scram_dsc.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scram_pkg.sv
// Shared constants and types for the self-synchronous scrambler/descrambler.
package scram_pkg;

    // Scrambler direction, selected by the MODE parameter
    localparam int unsigned MODE_SCR = 0;
    localparam int unsigned MODE_DSC = 1;

    // Width of the error counter output
    localparam int unsigned ERR_W = 16;

    // Consecutive nonzero beats in lock that force a return to hunt
    localparam int unsigned LOSS_N = 4;

    // PRBS lock checker states
    typedef enum logic [1:0] {
        StHunt,
        StCheck,
        StLock
    } lock_st_e;

endpackage

// File: rtl/scram_core.sv
// Combinational DW-step unroll of the self-synchronous LFSR.
// History register: bit 0 is the most recent bit (delay 1), bit k-1 is delay k.
// Beats are processed MSB first; each bit sees the history left by the bit before it.
module scram_core
    import scram_pkg::*;
#(
    parameter int unsigned DW   = 62,
    parameter int unsigned PP   = 58,
    parameter logic [PP:0] POLY = 59'h400008000000001,
    parameter int unsigned MODE = MODE_SCR
) (
    input  logic [PP-1:0] st_cur,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [PP-1:0] st_nxt
);

    // Delay-k tap lines up with history bit k-1; POLY bit 0 is the implicit "+1"
    localparam logic [PP-1:0] TAPS = POLY[PP:1];

    logic [PP-1:0] hist;
    logic [DW-1:0] dsh;
    logic          b_in;
    logic          b_out;

    // Serial steps unrolled across the beat, MSB first in time
    always_comb begin
        hist  = st_cur;
        dsh   = din;
        dout  = '0;
        b_in  = 1'b0;
        b_out = 1'b0;
        for (int j = 0; j < int'(DW); j++) begin
            b_in  = dsh[DW-1];
            b_out = b_in ^ (^(hist & TAPS));
            dsh   = dsh << 1;
            dout  = (dout << 1) | DW'(b_out);
            // Scrambler feeds back its output; descrambler feeds back the line bits
            hist  = (hist << 1) | PP'((MODE == MODE_DSC) ? b_in : b_out);
        end
        st_nxt = hist;
    end

endmodule

// File: rtl/scram_dsc.sv
// Self-synchronous scrambler/descrambler with a one-entry output stage.
// Optional PRBS lock/error checker compiled only when SCRAM_LOCK_EN is defined.
module scram_dsc
    import scram_pkg::*;
#(
    parameter int unsigned   DW     = 62,
    parameter int unsigned   PP     = 58,
    parameter logic [PP:0]   POLY   = 59'h400008000000001,
    parameter logic [PP-1:0] SI     = {PP{1'b1}},
    parameter int unsigned   MODE   = MODE_SCR,
    parameter int unsigned   LOCK_N = 16
) (
    input  logic             Ck,
    input  logic             Rs_n,
    input  logic             CE,
    input  logic             Scr_En,
    input  logic             Seed_Ld,
    input  logic             In_Vld,
    output logic             In_Rdy,
    input  logic [DW-1:0]    Dat_i,
    output logic             Out_Vld,
    input  logic             Out_Rdy,
    output logic [DW-1:0]    Dat_o,
    output logic             Lock,
    output logic [ERR_W-1:0] Err_Cnt
);

    logic [PP-1:0] st_q;
    logic [PP-1:0] st_cur;
    logic [PP-1:0] st_nxt;
    logic [DW-1:0] scr_dat;
    logic [DW-1:0] beat_dat;
    logic          in_fire;
    logic          out_fire;

    assign In_Rdy   = !Out_Vld || Out_Rdy;
    assign in_fire  = In_Vld && In_Rdy && CE;
    assign out_fire = Out_Vld && Out_Rdy && CE;

    // A seed load on the same cycle as a transfer scrambles that beat from SI
    assign st_cur   = Seed_Ld ? SI : st_q;
    assign beat_dat = Scr_En ? scr_dat : Dat_i;

    scram_core #(
        .DW   (DW),
        .PP   (PP),
        .POLY (POLY),
        .MODE (MODE)
    ) u_core (
        .st_cur (st_cur),
        .din    (Dat_i),
        .dout   (scr_dat),
        .st_nxt (st_nxt)
    );

    // LFSR history: advances only on scrambled input transfers
    always_ff @(posedge Ck or negedge Rs_n) begin
        if (!Rs_n) begin
            st_q <= SI;
        end else if (CE) begin
            if (in_fire && Scr_En) begin
                st_q <= st_nxt;
            end else if (Seed_Ld) begin
                st_q <= SI;
            end
        end
    end

    // Output stage: load on input transfer, empty on output transfer
    always_ff @(posedge Ck or negedge Rs_n) begin
        if (!Rs_n) begin
            Out_Vld <= 1'b0;
            Dat_o   <= '0;
        end else if (in_fire) begin
            Out_Vld <= 1'b1;
            Dat_o   <= beat_dat;
        end else if (out_fire) begin
            Out_Vld <= 1'b0;
        end
    end

`ifdef SCRAM_LOCK_EN
    localparam int unsigned    GW        = (LOCK_N > 1) ? $clog2(LOCK_N + 1) : 1;
    localparam logic [GW-1:0]  GOOD_LAST = GW'(LOCK_N - 1);
    localparam logic [2:0]     BAD_LAST  = 3'(LOSS_N - 1);

    lock_st_e         lk_q, lk_d;
    logic [GW-1:0]    good_q, good_d;
    logic [2:0]       bad_q, bad_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [ERR_W:0]   err_sum;
    logic             beat_zero;

    assign beat_zero = (beat_dat == '0);
    assign err_sum   = {1'b0, err_q} + (ERR_W + 1)'($countones(beat_dat));

    // Lock FSM next state and error accumulation, evaluated per output beat
    always_comb begin
        lk_d   = lk_q;
        good_d = good_q;
        bad_d  = bad_q;
        err_d  = err_q;
        if (Seed_Ld) begin
            lk_d   = StHunt;
            good_d = '0;
            bad_d  = '0;
            err_d  = '0;
        end else if (in_fire) begin
            unique case (lk_q)
                StHunt: begin
                    if (beat_zero) begin
                        lk_d   = StCheck;
                        good_d = GW'(1);
                    end
                end
                StCheck: begin
                    if (!beat_zero) begin
                        lk_d   = StHunt;
                        good_d = '0;
                    end else if (good_q >= GOOD_LAST) begin
                        lk_d  = StLock;
                        bad_d = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                StLock: begin
                    err_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
                    if (beat_zero) begin
                        bad_d = '0;
                    end else if (bad_q == BAD_LAST) begin
                        lk_d   = StHunt;
                        bad_d  = '0;
                        good_d = '0;
                    end else begin
                        bad_d = bad_q + 1'b1;
                    end
                end
                default: begin
                    lk_d = StHunt;
                end
            endcase
        end
    end

    // Lock FSM and counter registers
    always_ff @(posedge Ck or negedge Rs_n) begin
        if (!Rs_n) begin
            lk_q   <= StHunt;
            good_q <= '0;
            bad_q  <= '0;
            err_q  <= '0;
        end else if (CE) begin
            lk_q   <= lk_d;
            good_q <= good_d;
            bad_q  <= bad_d;
            err_q  <= err_d;
        end
    end

    assign Lock    = (lk_q == StLock);
    assign Err_Cnt = err_q;
`else
    assign Lock    = 1'b0;
    assign Err_Cnt = '0;
`endif

endmodule

// File: tb/tb_scram_dsc.sv
// Bench for scram_dsc: scrambler feeding descrambler, plus DW=1 / DW=8 scramblers.
// Expected beats are queued by the stimulus and popped by a negedge monitor.
module tb_scram_dsc;

`ifdef SCRAM_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic Ck = 1'b0;
    logic Rs_n = 1'b0;
    logic CE = 1'b1;
    always #5 Ck = ~Ck;

    // Scrambler A
    logic        a_scr_en = 1'b1;
    logic        a_seed = 1'b0;
    logic        a_vld = 1'b0;
    logic [61:0] a_din = '0;
    logic        a_in_rdy, a_out_vld, a_lock;
    logic [61:0] a_dout;
    logic [15:0] a_err;

    // Descrambler B, fed by A
    logic        b_in_rdy, b_out_vld, b_lock;
    logic        b_out_rdy = 1'b1;
    logic [61:0] b_dout;
    logic [15:0] b_err;

    // Narrow scramblers C (DW=1) and D (DW=8)
    logic        cd_vld = 1'b0;
    logic [7:0]  cd_din = '0;
    logic        c_in_rdy, c_out_vld, c_lock, d_in_rdy, d_out_vld, d_lock;
    logic [0:0]  c_dout;
    logic [7:0]  d_dout;
    logic [15:0] c_err, d_err;

    scram_dsc #(.MODE(0)) u_a (
        .Ck(Ck), .Rs_n(Rs_n), .CE(CE), .Scr_En(a_scr_en), .Seed_Ld(a_seed),
        .In_Vld(a_vld), .In_Rdy(a_in_rdy), .Dat_i(a_din),
        .Out_Vld(a_out_vld), .Out_Rdy(b_in_rdy), .Dat_o(a_dout),
        .Lock(a_lock), .Err_Cnt(a_err)
    );

    scram_dsc #(.MODE(1)) u_b (
        .Ck(Ck), .Rs_n(Rs_n), .CE(CE), .Scr_En(1'b1), .Seed_Ld(1'b0),
        .In_Vld(a_out_vld), .In_Rdy(b_in_rdy), .Dat_i(a_dout),
        .Out_Vld(b_out_vld), .Out_Rdy(b_out_rdy), .Dat_o(b_dout),
        .Lock(b_lock), .Err_Cnt(b_err)
    );

    scram_dsc #(.DW(1), .PP(7), .POLY(8'hC1), .SI(7'h7F), .MODE(0)) u_c (
        .Ck(Ck), .Rs_n(Rs_n), .CE(CE), .Scr_En(1'b1), .Seed_Ld(1'b0),
        .In_Vld(cd_vld), .In_Rdy(c_in_rdy), .Dat_i(cd_din[0:0]),
        .Out_Vld(c_out_vld), .Out_Rdy(1'b1), .Dat_o(c_dout),
        .Lock(c_lock), .Err_Cnt(c_err)
    );

    scram_dsc #(.DW(8), .PP(7), .POLY(8'hC1), .SI(7'h7F), .MODE(0)) u_d (
        .Ck(Ck), .Rs_n(Rs_n), .CE(CE), .Scr_En(1'b1), .Seed_Ld(1'b0),
        .In_Vld(cd_vld), .In_Rdy(d_in_rdy), .Dat_i(cd_din),
        .Out_Vld(d_out_vld), .Out_Rdy(1'b1), .Dat_o(d_dout),
        .Lock(d_lock), .Err_Cnt(d_err)
    );

    int checks = 0;
    int errors = 0;
    bit chk_b = 1'b1;
    int b_mode = 0;     // 0: always ready, 1: random stalls, 2: held low
    bit ce_rand = 1'b0;

    logic [61:0] exp_a[$];
    logic [61:0] exp_b[$];
    logic [61:0] exp_c[$];
    logic [61:0] exp_d[$];

    // Scrambled bit streams, oldest first; bits before the stream start read as seed ones
    bit hist_a[$];
    bit hist_c[$];
    bit hist_d[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic bit past(input int id, input int k);
        case (id)
            0:       return (hist_a.size() >= k) ? hist_a[hist_a.size() - k] : 1'b1;
            1:       return (hist_c.size() >= k) ? hist_c[hist_c.size() - k] : 1'b1;
            default: return (hist_d.size() >= k) ? hist_d[hist_d.size() - k] : 1'b1;
        endcase
    endfunction

    task automatic push_hist(input int id, input bit b);
        case (id)
            0: begin hist_a.push_back(b); if (hist_a.size() > 256) void'(hist_a.pop_front()); end
            1: begin hist_c.push_back(b); if (hist_c.size() > 256) void'(hist_c.pop_front()); end
            default: begin hist_d.push_back(b); if (hist_d.size() > 256) void'(hist_d.pop_front()); end
        endcase
    endtask

    // Reference: out[n] = in[n] ^ out[n-t1] ^ out[n-t2], bits taken MSB first
    task automatic model_beat(input int id, input logic [61:0] d, input int dw, input bit scr,
                              output logic [61:0] q);
        int t1, t2;
        bit b;
        q = '0;
        if (!scr) begin
            q = d;
            return;
        end
        t1 = (id == 0) ? 58 : 7;
        t2 = (id == 0) ? 39 : 6;
        for (int j = dw - 1; j >= 0; j--) begin
            b = d[j] ^ past(id, t1) ^ past(id, t2);
            q[j] = b;
            push_hist(id, b);
        end
    endtask

    function automatic logic [61:0] rnd62();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[61:0];
    endfunction

    // Ready / clock-enable drivers, changed just after the active edge
    always @(posedge Ck) begin
        #1;
        b_out_rdy = (b_mode == 2) ? 1'b0 : (b_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        CE = ce_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
    end

    // Monitor: pop and compare on every output transfer
    always @(negedge Ck) begin
        if (Rs_n && CE) begin
            if (a_out_vld && b_in_rdy) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL a_extra: got beat %h expected none", a_dout);
                end else begin
                    checks--;
                    chk("a_data", {2'b0, a_dout}, {2'b0, exp_a.pop_front()});
                end
            end
            if (b_out_vld && b_out_rdy && chk_b) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL b_extra: got beat %h expected none", b_dout);
                end else begin
                    checks--;
                    chk("b_data", {2'b0, b_dout}, {2'b0, exp_b.pop_front()});
                end
            end
            if (c_out_vld && exp_c.size() != 0) chk("c_data", {63'b0, c_dout}, {2'b0, exp_c.pop_front()});
            if (d_out_vld && exp_d.size() != 0) chk("d_data", {56'b0, d_dout}, {2'b0, exp_d.pop_front()});
        end
    end

    task automatic send_a(input logic [61:0] d, input bit seed);
        int n;
        logic [61:0] q;
        n = 0;
        a_vld = 1'b1;
        a_din = d;
        a_seed = seed;
        @(negedge Ck);
        while (!(a_in_rdy && CE && Rs_n)) begin
            n++;
            if (n > 200) begin
                chk("send_a_timeout", 64'd0, 64'd1);
                break;
            end
            @(negedge Ck);
        end
        if (n <= 200) begin
            if (seed) hist_a.delete();
            model_beat(0, d, 62, a_scr_en, q);
            exp_a.push_back(q);
            if (chk_b) exp_b.push_back(d);
        end
        @(posedge Ck);
        #1;
        a_vld = 1'b0;
        a_seed = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() + exp_b.size() + exp_c.size() + exp_d.size()) != 0 && n < 500) begin
            @(negedge Ck);
            n++;
        end
        chk("drain_left", 64'(exp_a.size() + exp_b.size() + exp_c.size() + exp_d.size()), 64'd0);
        @(posedge Ck);
        #1;
    endtask

    task automatic apply_reset();
        #2;
        Rs_n = 1'b0;
        a_vld = 1'b0;
        a_seed = 1'b0;
        cd_vld = 1'b0;
        exp_a.delete(); exp_b.delete(); exp_c.delete(); exp_d.delete();
        hist_a.delete(); hist_c.delete(); hist_d.delete();
        @(negedge Ck);
        chk("rst_a_out_vld", {63'b0, a_out_vld}, 64'd0);
        chk("rst_a_dat_o", {2'b0, a_dout}, 64'd0);
        chk("rst_b_out_vld", {63'b0, b_out_vld}, 64'd0);
        chk("rst_b_lock", {63'b0, b_lock}, 64'd0);
        chk("rst_b_err_cnt", {48'b0, b_err}, 64'd0);
        @(posedge Ck);
        #1;
        Rs_n = 1'b1;
        @(posedge Ck);
        #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [61:0] hold, m, q;
        int p0, p1, p2;

        apply_reset();

        // Zero input for 100 beats, full throughput
        b_mode = 0;
        for (int i = 0; i < 100; i++) send_a('0, 1'b0);
        drain();

        // Random data through scrambler then descrambler with stalls and CE gaps
        b_mode = 1;
        ce_rand = 1'b1;
        for (int i = 0; i < 150; i++) send_a(rnd62(), 1'b0);
        drain();
        ce_rand = 1'b0;

        // Hold the chain stalled for 5 cycles with input pending
        b_mode = 2;
        fork
            begin
                for (int i = 0; i < 4; i++) send_a(rnd62(), 1'b0);
            end
            begin
                for (int i = 0; i < 50 && !(a_out_vld && !b_in_rdy); i++) @(negedge Ck);
                chk("stall_reached", {63'b0, a_out_vld && !b_in_rdy}, 64'd1);
                hold = a_dout;
                repeat (5) begin
                    @(negedge Ck);
                    chk("stall_in_rdy", {63'b0, a_in_rdy}, 64'd0);
                    chk("stall_dat_o", {2'b0, a_dout}, {2'b0, hold});
                end
                b_mode = 0;
            end
        join
        drain();

        // Zero stream to acquire lock, then one beat carrying three bit errors
        apply_reset();
        b_mode = 0;
        for (int i = 0; i < 18; i++) send_a('0, 1'b0);
        drain();
        chk("lock_acquire", {63'b0, b_lock}, {63'b0, LockEn});
        p0 = $urandom_range(0, 61);
        p1 = (p0 + 1 + $urandom_range(0, 19)) % 62;
        p2 = (p0 + 21 + $urandom_range(0, 19)) % 62;
        m = '0;
        m[p0] = 1'b1;
        m[p1] = 1'b1;
        m[p2] = 1'b1;
        send_a(m, 1'b0);
        for (int i = 0; i < 4; i++) send_a('0, 1'b0);
        drain();
        chk("err_cnt", {48'b0, b_err}, LockEn ? 64'($countones(m)) : 64'd0);
        chk("lock_hold", {63'b0, b_lock}, {63'b0, LockEn});

        // Seed load coincident with a transfer, then reset during a stall
        apply_reset();
        chk_b = 1'b0;
        for (int i = 0; i < 3; i++) send_a(rnd62(), 1'b0);
        send_a(rnd62(), 1'b1);
        send_a(rnd62(), 1'b0);
        drain();
        b_mode = 2;
        send_a(rnd62(), 1'b0);
        send_a(rnd62(), 1'b0);
        a_vld = 1'b1;
        a_din = rnd62();
        repeat (3) @(posedge Ck);
        #3;
        apply_reset();
        b_mode = 0;
        repeat (5) @(negedge Ck);
        chk("no_replay_out_vld", {63'b0, a_out_vld}, 64'd0);
        chk("post_rst_lock", {63'b0, b_lock}, 64'd0);
        chk("post_rst_err", {48'b0, b_err}, 64'd0);
        @(posedge Ck);
        #1;

        // Scrambling switched on and off per beat
        for (int i = 0; i < 40; i++) begin
            a_scr_en = ($urandom_range(0, 2) != 0);
            send_a(rnd62(), 1'b0);
        end
        drain();
        a_scr_en = 1'b1;
        apply_reset();
        chk_b = 1'b1;

        // Narrow beats: DW=1 and DW=8 against serial x^7+x^6+1
        for (int i = 0; i < 60; i++) begin
            cd_vld = 1'b1;
            cd_din = 8'($urandom());
            @(negedge Ck);
            chk("cd_in_rdy", {62'b0, c_in_rdy, d_in_rdy}, 64'd3);
            model_beat(1, {61'b0, cd_din[0]}, 1, 1'b1, q);
            exp_c.push_back(q);
            model_beat(2, {54'b0, cd_din}, 8, 1'b1, q);
            exp_d.push_back(q);
            @(posedge Ck);
            #1;
        end
        cd_vld = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
